// File: rtl/tx_word_framer.sv
// tx_word_framer: queues words and sends each as a byte stream over a start/busy handshake
module tx_word_framer #(
    parameter int WORD_BYTES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter logic [7:0] HEADER = 8'hA5,
    localparam int W = 8 * WORD_BYTES,
    localparam int CW = $clog2(WORD_BYTES + 1),
    localparam int FCW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_word,
    input  logic [CW-1:0]  in_bytes,
    input  logic           in_msb_first,
    input  logic           in_frame,
    output logic           busy,
    output logic [FCW-1:0] fifo_count,
    output logic [7:0]     tx_data,
    output logic           tx_start,
    input  logic           tx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = W + CW + 2;

    typedef enum logic [2:0] {IDLE, LOAD, REQ, ACK, WAIT, NEXT} state_t;
    typedef enum logic [1:0] {PH_HDR, PH_PAY, PH_CHK} phase_t;

    state_t state, state_nx;
    phase_t phase;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [FCW-1:0] count;
    logic [W-1:0] shreg, head_word;
    logic [CW-1:0] cnt, n_clamp, pop_n;
    logic msb, frame, push, pop;
    logic [7:0] chk, sel, pay;

    assign in_ready = count != FCW'(FIFO_DEPTH);
    assign push = in_valid && in_ready;
    assign pop = state == IDLE && count != '0;
    assign busy = state != IDLE || count != '0;
    assign fifo_count = count;
    assign n_clamp = in_bytes > CW'(WORD_BYTES) ? CW'(WORD_BYTES) : in_bytes;
    assign head = mem[rd_ptr];
    assign head_word = head[EW-1 -: W];
    assign pop_n = head[CW+1:2];
    assign pay = msb ? shreg[W-1 -: 8] : shreg[7:0];

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {in_word, n_clamp, in_msb_first, in_frame};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + FCW'(push) - FCW'(pop);
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = pop ? LOAD : IDLE;
            LOAD:    state_nx = (!frame && cnt == '0) ? IDLE : REQ;
            REQ:     state_nx = ACK;
            ACK:     state_nx = tx_busy ? WAIT : ACK;
            WAIT:    state_nx = tx_busy ? WAIT : NEXT;
            NEXT:    state_nx = (phase == PH_CHK || (phase == PH_PAY && cnt == '0 && !frame)) ? IDLE : REQ;
            default: state_nx = IDLE;
        endcase
    end

    // MSB-first words are left-aligned at pop so the next byte is always at the top
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            shreg    <= '0;
            cnt      <= '0;
            msb      <= 1'b0;
            frame    <= 1'b0;
            chk      <= '0;
            sel      <= '0;
            phase    <= PH_HDR;
            tx_data  <= '0;
            tx_start <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    shreg <= head[1] ? head_word << (8 * (WORD_BYTES - int'(pop_n))) : head_word;
                    cnt   <= pop_n;
                    msb   <= head[1];
                    frame <= head[0];
                    chk   <= '0;
                end
                LOAD: begin
                    sel   <= frame ? HEADER : pay;
                    phase <= frame ? PH_HDR : PH_PAY;
                end
                REQ: begin
                    tx_data  <= sel;
                    tx_start <= 1'b1;
                end
                ACK: if (tx_busy) begin
                    tx_start <= 1'b0;
                    if (phase == PH_PAY) begin
                        chk   <= chk ^ tx_data;
                        cnt   <= cnt - CW'(1);
                        shreg <= msb ? shreg << 8 : shreg >> 8;
                    end
                end
                NEXT: begin
                    sel   <= cnt != '0 ? pay : chk;
                    phase <= cnt != '0 ? PH_PAY : PH_CHK;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_tx_word_framer.sv
// tb_tx_word_framer: directed vectors against a simple transmitter model that logs every start pulse
module tb_tx_word_framer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic [2:0]  in_bytes = '0;
    logic        in_msb_first = 1'b0;
    logic        in_frame = 1'b0;
    logic        busy;
    logic [2:0]  fifo_count;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;

    logic        stall = 1'b0;
    logic        start_q;
    int          bcnt;
    logic [7:0]  got[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          base;
    int          k;

    tx_word_framer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .in_bytes(in_bytes), .in_msb_first(in_msb_first),
        .in_frame(in_frame), .busy(busy), .fifo_count(fifo_count),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    // transmitter: busy for 10 cycles after each start, every rising start logs one byte
    assign tx_busy = stall || bcnt != 0;
    always @(negedge clk)
        if (!rst_n) begin
            bcnt    <= 0;
            start_q <= 1'b0;
        end else begin
            start_q <= tx_start;
            if (tx_start && !start_q) got.push_back(tx_data);
            if (bcnt != 0) bcnt <= bcnt - 1;
            else if (tx_start) bcnt <= 10;
        end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic [2:0] n, input logic m, input logic f);
        in_word = w; in_bytes = n; in_msb_first = m; in_frame = f; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 500 && (busy || tx_busy); i++) @(negedge clk);
        check({tag, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_seq(input string tag, input int from, input int n, input logic [63:0] exp);
        check({tag, " count"}, got.size() - from, n);
        for (int i = 0; i < n; i++)
            check($sformatf("%s byte%0d", tag, i), (from + i < got.size()) ? {24'd0, got[from + i]} : 32'hFFFF, {24'd0, exp[8*i +: 8]});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst tx_start", {31'd0, tx_start}, 32'd0);
        check("rst tx_data", {24'd0, tx_data}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst fifo_count", {29'd0, fifo_count}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        base = got.size();
        push(32'h11223344, 3'd4, 1'b0, 1'b0);
        wait_idle("lsb4");
        expect_seq("lsb4", base, 4, 64'h11_22_33_44);

        base = got.size();
        push(32'h11223344, 3'd3, 1'b1, 1'b1);
        wait_idle("msb3f");
        expect_seq("msb3f", base, 5, 64'h55_44_33_22_A5);

        base = got.size();
        push(32'h11223344, 3'd0, 1'b0, 1'b1);
        wait_idle("n0f");
        expect_seq("n0f", base, 2, 64'h00_A5);

        base = got.size();
        push(32'h11223344, 3'd0, 1'b0, 1'b0);
        k = 0;
        while (busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("n0u settle", {31'd0, k <= 3}, 32'd1);
        wait_idle("n0u");
        expect_seq("n0u", base, 0, 64'h0);

        base = got.size();
        stall = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            in_word = i; in_bytes = 3'd1; in_msb_first = 1'b0; in_frame = 1'b0; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("full fifo_count", {29'd0, fifo_count}, 32'd4);
        check("full in_ready", {31'd0, in_ready}, 32'd0);
        stall = 1'b0;
        wait_idle("stall");
        expect_seq("stall", base, 5, 64'h05_04_03_02_01);

        base = got.size();
        push(32'hDEADBEEF, 3'd7, 1'b0, 1'b1);
        wait_idle("clamp");
        expect_seq("clamp", base, 6, 64'h22_DE_AD_BE_EF_A5);

        base = got.size();
        push(32'h11223344, 3'd4, 1'b0, 1'b0);
        push(32'h00000099, 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 200 && got.size() < base + 2; i++) @(negedge clk);
        check("abort second byte", got.size() - base, 2);
        check("abort queued", {29'd0, fifo_count}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort tx_start", {31'd0, tx_start}, 32'd0);
        check("abort fifo_count", {29'd0, fifo_count}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        base = got.size();
        push(32'h0000CAFE, 3'd2, 1'b1, 1'b0);
        wait_idle("post");
        expect_seq("post", base, 2, 64'hFE_CA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
